comparator_sweep_sequencer: RTL and testbench
=============================================

COMPARATOR_SWEEP_SEQUENCER -- requirements
Module: comparator_sweep_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, sets the number of cycles each B value is held before cmp_gt is sampled; the legal range is 1..15.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  is the asynchronous, active-high reset.
REQ-005 start  input  1  is a sweep request, sampled only in IDLE.
REQ-006 a_in  input  2  is the A operand, captured when start is accepted.
REQ-007 cmp_gt  input  1  is the greater-than result from the downstream two-bit comparator (1 when cmp_a > cmp_b).
REQ-008 cmp_a  output  2  is the A operand driven to the comparator.
REQ-009 cmp_b  output  2  is the B operand driven to the comparator.
REQ-010 busy  output  1  is high while a sweep is in progress.
REQ-011 done  output  1  is a one-cycle pulse marking sweep completion.
REQ-012 gt_mask  output  4  holds the sweep result: bit k = cmp_gt observed with cmp_b==k.
REQ-013 gt_count  output  3  is the number of set bits in gt_mask (0..4).

Function
REQ-014 The FSM SHALL have four states: IDLE, DRIVE, SAMPLE and DONE.
REQ-015 When in IDLE with start=1, the following SHALL happen on the next edge:
- cmp_a <= a_in; cmp_b <= 0;
- gt_mask <= 0; gt_count <= 0;
- settle counter <= 0;
- next state DRIVE.
REQ-016 In IDLE with start=0, all outputs SHALL hold, and gt_mask/gt_count SHALL retain the last sweep result.
REQ-017 In DRIVE, the settle counter SHALL increment each cycle; the FSM goes to SAMPLE on the edge where the counter equals SETTLE_CYCLES-1.
REQ-018 In SAMPLE, the block SHALL do the following:
- gt_mask[cmp_b] <= cmp_gt;
- gt_count increments by 1 when cmp_gt=1.
REQ-019 On leaving SAMPLE, the block SHALL do the following:
- if cmp_b==3, go to DONE;
- otherwise cmp_b <= cmp_b+1, settle counter <= 0, go to DRIVE.
REQ-020 In DONE, done=1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-021 Each B value SHALL occupy SETTLE_CYCLES+1 cycles.
REQ-022 done SHALL be high in the cycle following edge 4*(SETTLE_CYCLES+1) counted from the edge that accepted start.
REQ-023 busy SHALL be 1 in DRIVE, SAMPLE and DONE, and 0 in IDLE.
REQ-024 start SHALL be ignored in DRIVE, SAMPLE and DONE, including start asserted during the done pulse.
REQ-025 A back-to-back sweep SHALL begin at the earliest on the edge after DONE returns to IDLE.
REQ-026 Changes on a_in after acceptance SHALL have no effect on cmp_a until the next accepted start.
REQ-027 cmp_a and cmp_b SHALL be driven only from registers, with no combinational path from start or a_in.
REQ-028 cmp_b SHALL never wrap from 3 to 0 within a sweep; cmp_b holds 3 through DONE and IDLE until the next start.
REQ-029 gt_mask and gt_count SHALL be valid and stable from the done pulse until the next accepted start.

Reset
REQ-030 On rst=1, the following SHALL apply immediately, without waiting for a clock edge:
- state=IDLE; cmp_a=0; cmp_b=0;
- busy=0; done=0;
- gt_mask=0; gt_count=0; settle counter=0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep with no done pulse.
REQ-032 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-033 The bench SHALL use an ideal comparator model for cmp_gt and cover these scenarios:
- SETTLE_CYCLES=1, a_in=2'b10, start pulse -> cmp_b steps 0,1,2,3; done after 8 edges; gt_mask=4'b0011; gt_count=2.
- a_in=2'b00 -> gt_mask=4'b0000, gt_count=0; a_in=2'b11 -> gt_mask=4'b0111, gt_count=3.
- start held high continuously, plus a_in changed mid-sweep -> exactly one sweep per IDLE entry, result computed with the originally captured a_in, and done pulses spaced 9 cycles apart.
- rst pulsed while cmp_b==2 (asynchronous, between edges) -> outputs zero immediately, no done pulse; next sweep runs correctly.
- SETTLE_CYCLES=3, a_in=2'b01 -> each cmp_b held 4 cycles; done after 16 edges; gt_mask=4'b0001; gt_count=1.

Source files
------------

// File: rtl/comparator_sweep_sequencer.sv
// Comparator sweep sequencer: holds a captured A operand on a two-bit
// comparator while stepping B through 0..3, waits SETTLE_CYCLES per step,
// then samples cmp_gt into a per-B result mask and a population count.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; last sweep result held on outputs
// DRIVE  | current B value driven, settle counter running
// SAMPLE | cmp_gt captured for current B, then step B or finish
// DONE   | one-cycle done pulse, result valid, returns to IDLE
module comparator_sweep_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] a_in,
  input  logic       cmp_gt,
  output logic [1:0] cmp_a,
  output logic [1:0] cmp_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] gt_mask,
  output logic [2:0] gt_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Settle counter is four bits wide to cover the full 1..15 range.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] settle_cnt;

  // Sweep FSM; every output is a register so the comparator operands
  // never see a combinational path from start or a_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmp_a      <= 2'd0;
      cmp_b      <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gt_mask    <= 4'd0;
      gt_count   <= 3'd0;
      settle_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cmp_a      <= a_in;
            cmp_b      <= 2'd0;
            gt_mask    <= 4'd0;
            gt_count   <= 3'd0;
            settle_cnt <= 4'd0;
            busy       <= 1'b1;
            state      <= DRIVE;
          end
        end

        DRIVE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          gt_mask[cmp_b] <= cmp_gt;
          gt_count       <= gt_count + {2'b00, cmp_gt};
          if (cmp_b == 2'd3) begin
            // B stays at 3 through DONE and IDLE; it never wraps mid-sweep.
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cmp_b      <= cmp_b + 2'd1;
            settle_cnt <= 4'd0;
            state      <= DRIVE;
          end
        end

        DONE: begin
          // start is deliberately not looked at here; a new sweep can only
          // be accepted from IDLE on the following edge.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_sweep_sequencer.sv
// Directed bench for comparator_sweep_sequencer. Two instances share clk and
// rst: one with SETTLE_CYCLES=1, one with SETTLE_CYCLES=3. cmp_gt comes from
// an ideal comparator model (cmp_a > cmp_b).
module tb_comparator_sweep_sequencer;

  logic clk = 1'b0;
  logic rst;

  logic       start1, start3;
  logic [1:0] a1, a3;
  logic       gt1, gt3;
  logic [1:0] ca1, cb1, ca3, cb3;
  logic       busy1, done1, busy3, done3;
  logic [3:0] m1, m3;
  logic [2:0] c1, c3;

  int checks   = 0;
  int failures = 0;
  bit sel3     = 1'b0;

  always #5 clk = ~clk;

  // Ideal downstream comparators.
  assign gt1 = (ca1 > cb1);
  assign gt3 = (ca3 > cb3);

  comparator_sweep_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .cmp_gt(gt1),
    .cmp_a(ca1), .cmp_b(cb1), .busy(busy1), .done(done1),
    .gt_mask(m1), .gt_count(c1)
  );

  comparator_sweep_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_in(a3), .cmp_gt(gt3),
    .cmp_a(ca3), .cmp_b(cb3), .busy(busy3), .done(done3),
    .gt_mask(m3), .gt_count(c3)
  );

  // Observation mux so the sweep task can watch either instance.
  logic [1:0] o_a, o_b;
  logic       o_busy, o_done;
  logic [3:0] o_mask;
  logic [2:0] o_cnt;

  always_comb begin
    o_a    = sel3 ? ca3   : ca1;
    o_b    = sel3 ? cb3   : cb1;
    o_busy = sel3 ? busy3 : busy1;
    o_done = sel3 ? done3 : done1;
    o_mask = sel3 ? m3    : m1;
    o_cnt  = sel3 ? c3    : c1;
  end

  // Runs one sweep on the selected instance and checks B stepping, done
  // timing at edge 4*(S+1) after acceptance, and the held result afterwards.
  // a_in is flipped mid-sweep; cmp_a must keep the captured value.
  task automatic do_sweep(input bit s3, input logic [1:0] a,
                          input logic [3:0] exp_mask, input logic [2:0] exp_cnt,
                          input string name);
    int per;
    int total;
    per   = s3 ? 4 : 2;
    total = 4 * per;
    sel3  = s3;
    @(negedge clk);
    if (s3) begin a3 = a; start3 = 1'b1; end
    else    begin a1 = a; start1 = 1'b1; end
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_b !== 2'd0 || o_a !== a || o_done !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept: busy=%b b=%0d a=%0d done=%b, expected busy=1 b=0 a=%0d done=0",
               name, o_busy, o_b, o_a, o_done, a);
    end
    for (int e = 1; e <= total; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin a1 = ~a; a3 = ~a; end
      if (e < total) begin
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b1 || o_b !== 2'(e / per) || o_a !== a) begin
          failures++;
          $display("FAIL %s_step%0d: done=%b busy=%b b=%0d a=%0d, expected done=0 busy=1 b=%0d a=%0d",
                   name, e, o_done, o_busy, o_b, o_a, e / per, a);
        end
      end else begin
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_mask !== exp_mask ||
            o_cnt !== exp_cnt || o_b !== 2'd3) begin
          failures++;
          $display("FAIL %s_done: done=%b busy=%b mask=%b cnt=%0d b=%0d, expected done=1 busy=1 mask=%b cnt=%0d b=3",
                   name, o_done, o_busy, o_mask, o_cnt, o_b, exp_mask, exp_cnt);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_mask !== exp_mask ||
          o_cnt !== exp_cnt || o_b !== 2'd3 || o_a !== a) begin
        failures++;
        $display("FAIL %s_hold%0d: done=%b busy=%b mask=%b cnt=%0d b=%0d a=%0d, expected done=0 busy=0 mask=%b cnt=%0d b=3 a=%0d",
                 name, k, o_done, o_busy, o_mask, o_cnt, o_b, o_a, exp_mask, exp_cnt, a);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; a1 = 2'd3; a3 = 2'd3;
    #2;
    checks++;
    if (ca1 !== 2'd0 || cb1 !== 2'd0 || busy1 !== 1'b0 || done1 !== 1'b0 ||
        m1 !== 4'd0 || c1 !== 3'd0) begin
      failures++;
      $display("FAIL reset_dut1: a=%0d b=%0d busy=%b done=%b mask=%b cnt=%0d, expected all zero",
               ca1, cb1, busy1, done1, m1, c1);
    end
    checks++;
    if (ca3 !== 2'd0 || cb3 !== 2'd0 || busy3 !== 1'b0 || done3 !== 1'b0 ||
        m3 !== 4'd0 || c3 !== 3'd0) begin
      failures++;
      $display("FAIL reset_dut3: a=%0d b=%0d busy=%b done=%b mask=%b cnt=%0d, expected all zero",
               ca3, cb3, busy3, done3, m3, c3);
    end
    // Deassert between the first and second rising edges.
    #5 rst = 1'b0;
  endtask

  // First sweep right after reset: also shows the first edge accepts start.
  task automatic test_sweep;
    do_sweep(1'b0, 2'b10, 4'b0011, 3'd2, "sweep_a2");
  endtask

  task automatic test_patterns;
    do_sweep(1'b0, 2'b00, 4'b0000, 3'd0, "sweep_a0");
    do_sweep(1'b0, 2'b11, 4'b0111, 3'd3, "sweep_a3");
  endtask

  task automatic test_settle3;
    do_sweep(1'b1, 2'b01, 4'b0001, 3'd1, "settle3_a1");
  endtask

  // start held high: one sweep per IDLE entry. Pulse period is 10 edges
  // (8 sweep edges, DONE->IDLE, IDLE->accept), i.e. nine non-done cycles
  // between consecutive pulses.
  task automatic test_back_to_back;
    int ndone;
    int t0, t1, t2;
    logic [3:0] mk0, mk1;
    logic [2:0] cn0;
    logic [1:0] a0;
    ndone = 0; t0 = -1; t1 = -1; t2 = -1;
    mk0 = 4'hx; mk1 = 4'hx; cn0 = 3'hx; a0 = 2'hx;
    sel3 = 1'b0;
    @(negedge clk);
    a1 = 2'b10; start1 = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (e == 3) a1 = 2'b00;
      if (done1 === 1'b1) begin
        if (ndone == 0) begin t0 = e; mk0 = m1; cn0 = c1; a0 = ca1; end
        else if (ndone == 1) begin t1 = e; mk1 = m1; end
        else if (ndone == 2) t2 = e;
        ndone++;
      end
    end
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (ndone != 3) begin
      failures++;
      $display("FAIL b2b_count: pulses=%0d, expected 3", ndone);
    end
    checks++;
    if (t0 != 8 || t1 - t0 != 10 || t2 - t1 != 10) begin
      failures++;
      $display("FAIL b2b_spacing: pulses at %0d,%0d,%0d, expected 8,18,28", t0, t1, t2);
    end
    checks++;
    if (mk0 !== 4'b0011 || cn0 !== 3'd2 || a0 !== 2'b10) begin
      failures++;
      $display("FAIL b2b_first_result: mask=%b cnt=%0d a=%0d, expected mask=0011 cnt=2 a=2",
               mk0, cn0, a0);
    end
    checks++;
    if (mk1 !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_second_result: mask=%b, expected 0000", mk1);
    end
    @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b done=%b, expected busy=0 done=0", busy1, done1);
    end
  endtask

  // Asynchronous reset while cmp_b==2 clears everything at once, no done.
  task automatic test_mid_reset;
    int ndone;
    sel3 = 1'b0;
    @(negedge clk);
    a1 = 2'b11; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (cb1 !== 2'd2 || m1 !== 4'b0011 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: b=%0d mask=%b busy=%b, expected b=2 mask=0011 busy=1",
               cb1, m1, busy1);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ca1 !== 2'd0 || cb1 !== 2'd0 || busy1 !== 1'b0 || done1 !== 1'b0 ||
        m1 !== 4'd0 || c1 !== 3'd0) begin
      failures++;
      $display("FAIL midrst_async: a=%0d b=%0d busy=%b done=%b mask=%b cnt=%0d, expected all zero",
               ca1, cb1, busy1, done1, m1, c1);
    end
    #1 rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1 || busy1 === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL midrst_no_done: active cycles=%0d, expected 0", ndone);
    end
    do_sweep(1'b0, 2'b01, 4'b0001, 3'd1, "midrst_next");
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_patterns();
    test_settle3();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
